// File: rtl/evt_burst_gen_if.sv
// Request/response bundle for evt_burst_gen: start/count/gap/abort in, status and event pulses out.
// Widths follow the same MAX_COUNT/MAX_GAP parameters as the generator.
interface evt_burst_gen_if #(
   parameter int MAX_COUNT = 16,
   parameter int MAX_GAP   = 15
);
   localparam int IW = $clog2(MAX_COUNT);
   localparam int GW = $clog2(MAX_GAP + 1);
   localparam int CW = $clog2(MAX_COUNT + 1);

   logic          start_in;
   logic [CW-1:0] count_in;
   logic [GW-1:0] gap_in;
   logic          abort_in;
   logic          ready_out;
   logic          busy_out;
   logic          evt_out;
   logic [IW-1:0] idx_out;
   logic          done_out;

   modport master (
      output start_in, count_in, gap_in, abort_in,
      input  ready_out, busy_out, evt_out, idx_out, done_out
   );

   modport slave (
      input  start_in, count_in, gap_in, abort_in,
      output ready_out, busy_out, evt_out, idx_out, done_out
   );
endinterface

// File: rtl/evt_burst_gen.sv
// Programmable burst of N single-cycle event pulses separated by G idle cycles, then done.
// Define EVT_BURST_ABORT_EN to let abort_in cut a burst short; otherwise bursts always complete.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready_out high, waiting for start_in
// EMIT   | evt_out high this cycle; idx_out is the pulse index
// GAP    | idle cycles between pulses, gap counter counting down
// DONE   | done_out high for one cycle, then back to IDLE
module evt_burst_gen #(
   parameter int MAX_COUNT = 16,
   parameter int MAX_GAP   = 15
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   evt_burst_gen_if.slave    bus
);
   localparam int IW = $clog2(MAX_COUNT);
   localparam int GW = $clog2(MAX_GAP + 1);
   localparam int CW = $clog2(MAX_COUNT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] n_q, n_d;
   logic [GW-1:0] g_q, g_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          evt_q, evt_d;
   logic          done_q, done_d;

   logic [CW-1:0] count_clamped;
   logic [GW-1:0] gap_clamped;
   logic          last_pulse;
   logic          abort_en;
   logic          abort_hit;

   // Clamp only exists when the input field can actually exceed the limit.
   if ((2 ** CW) - 1 > MAX_COUNT) begin : g_count_clamp
      assign count_clamped = (bus.count_in > CW'(MAX_COUNT)) ? CW'(MAX_COUNT) : bus.count_in;
   end else begin : g_count_pass
      assign count_clamped = bus.count_in;
   end

   if ((2 ** GW) - 1 > MAX_GAP) begin : g_gap_clamp
      assign gap_clamped = (bus.gap_in > GW'(MAX_GAP)) ? GW'(MAX_GAP) : bus.gap_in;
   end else begin : g_gap_pass
      assign gap_clamped = bus.gap_in;
   end

`ifdef EVT_BURST_ABORT_EN
   assign abort_en = 1'b1;
`else
   assign abort_en = 1'b0;
`endif

   assign abort_hit  = abort_en & bus.abort_in;
   assign last_pulse = (CW'(idx_q) + CW'(1)) == n_q;

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      g_d       = g_q;
      gap_cnt_d = gap_cnt_q;
      idx_d     = idx_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start_in) begin
               n_d       = count_clamped;
               g_d       = gap_clamped;
               idx_d     = '0;
               gap_cnt_d = '0;
               state_d   = (count_clamped == '0) ? S_DONE : S_EMIT;
            end
         end
         S_EMIT: begin
            if (abort_hit || last_pulse) begin
               state_d = S_DONE;
            end else if (g_q == '0) begin
               idx_d = idx_q + IW'(1);
            end else begin
               gap_cnt_d = g_q;
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - GW'(1);
            if (abort_hit) begin
               state_d = S_DONE;
            end else if (gap_cnt_q == GW'(1)) begin
               idx_d   = idx_q + IW'(1);
               state_d = S_EMIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered copies of the next-state decode.
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d == S_EMIT) || (state_d == S_GAP);
      evt_d   = (state_d == S_EMIT);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         g_q       <= '0;
         gap_cnt_q <= '0;
         idx_q     <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         evt_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         g_q       <= g_d;
         gap_cnt_q <= gap_cnt_d;
         idx_q     <= idx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         evt_q     <= evt_d;
         done_q    <= done_d;
      end
   end

   assign bus.ready_out = ready_q;
   assign bus.busy_out  = busy_q;
   assign bus.evt_out   = evt_q;
   assign bus.idx_out   = idx_q;
   assign bus.done_out  = done_q;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Directed bench for evt_burst_gen: burst timing, clamping, held start, abort and mid-burst reset.
// Expected abort behaviour follows whether EVT_BURST_ABORT_EN is defined for the build.
module tb_evt_burst_gen;
   logic clk_in;
   logic rst_n_in;

   int checks;
   int failures;

   evt_burst_gen_if #(.MAX_COUNT(16), .MAX_GAP(15)) bus();

   evt_burst_gen #(.MAX_COUNT(16), .MAX_GAP(15)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Issues one request from IDLE and follows it until ready_out returns.
   // Cycle numbers are relative to the accept edge (cycle 1 = first cycle after it).
   // idx_err counts pulses whose idx_out differs from a downstream event counter.
   task automatic do_burst(input int cnt, input int gap, input int abort_at,
                           input bit hold_start, input bit abort_with_start,
                           output int pulses, output int first_at, output int second_at,
                           output int last_idx, output int done_at, output int ready_at,
                           output int idx_err, output int busy_err);
      pulses   = 0;
      first_at = -1;
      second_at = -1;
      last_idx = -1;
      done_at  = -1;
      ready_at = -1;
      idx_err  = 0;
      busy_err = 0;
      bus.start_in = 1'b1;
      bus.count_in = 5'(cnt);
      bus.gap_in   = 4'(gap);
      bus.abort_in = abort_with_start;
      tick();
      bus.abort_in = 1'b0;
      if (!hold_start) bus.start_in = 1'b0;
      for (int cyc = 1; cyc < 200 && ready_at < 0; cyc++) begin
         if (bus.evt_out) begin
            if (int'(bus.idx_out) != pulses) idx_err++;
            if (pulses == 0) first_at = cyc;
            if (pulses == 1) second_at = cyc;
            if (pulses == abort_at) bus.abort_in = 1'b1;
            last_idx = int'(bus.idx_out);
            pulses++;
         end
         if (bus.done_out && done_at < 0) done_at = cyc;
         if (bus.ready_out) begin
            ready_at = cyc;
         end else if (bus.busy_out != (done_at < 0)) begin
            busy_err++;
         end
         if (ready_at < 0) begin
            tick();
            bus.abort_in = 1'b0;
         end
      end
      bus.start_in = 1'b0;
   endtask

   int p, f1, f2, li, dn, rd, ie, be, rst_pulses;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n_in = 1'b1;
      bus.start_in = 1'b0;
      bus.count_in = '0;
      bus.gap_in   = '0;
      bus.abort_in = 1'b0;
      #1 rst_n_in = 1'b0;
      #1;
      chk("rst_ready", int'(bus.ready_out), 1);
      chk("rst_busy",  int'(bus.busy_out), 0);
      chk("rst_evt",   int'(bus.evt_out), 0);
      chk("rst_done",  int'(bus.done_out), 0);
      chk("rst_idx",   int'(bus.idx_out), 0);
      repeat (2) tick();
      rst_n_in = 1'b1;

      // N=3 G=0: pulses in cycles 1..3, done 4, ready 5
      do_burst(3, 0, -1, 1'b0, 1'b0, p, f1, f2, li, dn, rd, ie, be);
      chk("n3g0_pulses", p, 3);
      chk("n3g0_first", f1, 1);
      chk("n3g0_second", f2, 2);
      chk("n3g0_lastidx", li, 2);
      chk("n3g0_done", dn, 4);
      chk("n3g0_ready", rd, 5);
      chk("n3g0_idxerr", ie, 0);
      chk("n3g0_busyerr", be, 0);
      tick();
      chk("n3g0_idx_hold", int'(bus.idx_out), 2);

      // N=2 G=2: pulses at 1 and 4, done 5, ready 6
      do_burst(2, 2, -1, 1'b0, 1'b0, p, f1, f2, li, dn, rd, ie, be);
      chk("n2g2_pulses", p, 2);
      chk("n2g2_first", f1, 1);
      chk("n2g2_second", f2, 4);
      chk("n2g2_done", dn, 5);
      chk("n2g2_ready", rd, 6);
      chk("n2g2_idxerr", ie, 0);
      chk("n2g2_busyerr", be, 0);

      // N=0 G=5: no pulses, done 1, ready 2, idx cleared
      do_burst(0, 5, -1, 1'b0, 1'b0, p, f1, f2, li, dn, rd, ie, be);
      chk("n0_pulses", p, 0);
      chk("n0_done", dn, 1);
      chk("n0_ready", rd, 2);
      chk("n0_idx", int'(bus.idx_out), 0);
      chk("n0_busyerr", be, 0);

      // count 31 clamps to 16, start held throughout
      do_burst(31, 0, -1, 1'b1, 1'b0, p, f1, f2, li, dn, rd, ie, be);
      chk("clamp_pulses", p, 16);
      chk("clamp_lastidx", li, 15);
      chk("clamp_done", dn, 17);
      chk("clamp_ready", rd, 18);
      chk("clamp_idxerr", ie, 0);
      tick();
      chk("clamp_idle_evt", int'(bus.evt_out), 0);
      chk("clamp_idx_hold", int'(bus.idx_out), 15);

      // N=8 G=1, abort in cycle of pulse 2 (pulses at 1,3,5)
      do_burst(8, 1, 2, 1'b0, 1'b0, p, f1, f2, li, dn, rd, ie, be);
`ifdef EVT_BURST_ABORT_EN
      chk("abort_pulses", p, 3);
      chk("abort_lastidx", li, 2);
      chk("abort_done", dn, 6);
      chk("abort_ready", rd, 7);
`else
      chk("noabort_pulses", p, 8);
      chk("noabort_lastidx", li, 7);
      chk("noabort_done", dn, 16);
      chk("noabort_ready", rd, 17);
`endif
      chk("abort_second", f2, 3);
      chk("abort_idxerr", ie, 0);

      // start and abort together in IDLE: start wins
      do_burst(2, 0, -1, 1'b0, 1'b1, p, f1, f2, li, dn, rd, ie, be);
      chk("startabort_pulses", p, 2);
      chk("startabort_done", dn, 3);
      chk("startabort_ready", rd, 4);

      // reset during GAP of an N=8 G=3 burst (pulse 1 at cycle 5, gap at 6)
      bus.start_in = 1'b1;
      bus.count_in = 5'd8;
      bus.gap_in   = 4'd3;
      tick();
      bus.start_in = 1'b0;
      repeat (5) tick();
      chk("midrst_pre_idx", int'(bus.idx_out), 1);
      chk("midrst_pre_evt", int'(bus.evt_out), 0);
      chk("midrst_pre_busy", int'(bus.busy_out), 1);
      #2 rst_n_in = 1'b0;
      #1;
      chk("midrst_ready", int'(bus.ready_out), 1);
      chk("midrst_busy", int'(bus.busy_out), 0);
      chk("midrst_evt", int'(bus.evt_out), 0);
      chk("midrst_done", int'(bus.done_out), 0);
      chk("midrst_idx", int'(bus.idx_out), 0);
      rst_pulses = 0;
      repeat (4) begin
         tick();
         if (bus.evt_out || bus.done_out) rst_pulses++;
      end
      chk("midrst_quiet", rst_pulses, 0);
      rst_n_in = 1'b1;
      do_burst(2, 0, -1, 1'b0, 1'b0, p, f1, f2, li, dn, rd, ie, be);
      chk("postrst_pulses", p, 2);
      chk("postrst_first", f1, 1);
      chk("postrst_idxerr", ie, 0);
      chk("postrst_done", dn, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
